coin_pulse_generator: RTL and testbench

- Stimulus-side counterpart to the coin detector: converts coin requests into `coinSensor` pulses of coin-specific width.
- A detector at the other end classifies each pulse as dime, nickel or quarter.
- Used as a synthesizable coin emulator in system benches and on the board.
- Requests arrive over a valid/ready handshake into a 4-entry FIFO. They are replayed as active-high pulses, each followed by a fixed low gap.

---
 rtl/coin_pkg.sv | 36 +++
 rtl/coin_pulse_generator_if.sv | 12 +
 rtl/coin_req_fifo.sv | 61 ++++++
 rtl/coin_pulse_generator.sv | 143 ++++++++++++++
 tb/tb_coin_pulse_generator.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/coin_pkg.sv
// Shared coin types, generator FSM states and default pulse widths/windows
// used by both the coin pulse generator and the coin detector.
package coin_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        DIME    = 2'd1,
        NICKEL  = 2'd2,
        QUARTER = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        GEN_IDLE  = 2'd0,
        GEN_PULSE = 2'd1,
        GEN_GAP   = 2'd2
    } gen_state_t;

    // Generator widths sit in the centre of the detector acceptance windows
    localparam int unsigned DEF_DIME_WIDTH    = 3;
    localparam int unsigned DEF_NICKEL_WIDTH  = 7;
    localparam int unsigned DEF_QUARTER_WIDTH = 11;
    localparam int unsigned DEF_GAP           = 2;
    localparam int unsigned DEF_DEPTH         = 4;

    localparam int unsigned DIME_MIN    = 2;
    localparam int unsigned DIME_MAX    = 4;
    localparam int unsigned NICKEL_MIN  = 6;
    localparam int unsigned NICKEL_MAX  = 8;
    localparam int unsigned QUARTER_MIN = 10;
    localparam int unsigned QUARTER_MAX = 12;

    function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/coin_pulse_generator_if.sv
// Coin request valid/ready handshake between a requester and the pulse generator.
interface coin_pulse_generator_if;
    import coin_pkg::*;

    logic  coin_valid;
    coin_t coin_type;
    logic  coin_ready;

    modport master (output coin_valid, output coin_type, input coin_ready);
    modport slave  (input coin_valid, input coin_type, output coin_ready);

endinterface

// File: rtl/coin_req_fifo.sv
// Request FIFO for coin types: synchronous push/pop, registered occupancy count,
// no bypass from push to pop data.
module coin_req_fifo
    import coin_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  coin_t pushData,
    input  logic  pop,
    output coin_t popData,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("coin_req_fifo: DEPTH must be a power of two >= 2");
    end

    coin_t          mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic [CW-1:0]  count;
    logic           doPush;
    logic           doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assign popData = mem[rdPtr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/coin_pulse_generator.sv
// Coin emulator: queues coin requests and replays each as an active-high
// coinSensor pulse of coin-specific width followed by a fixed low gap.
module coin_pulse_generator
    import coin_pkg::*;
#(
    parameter int unsigned DIME_WIDTH    = DEF_DIME_WIDTH,
    parameter int unsigned NICKEL_WIDTH  = DEF_NICKEL_WIDTH,
    parameter int unsigned QUARTER_WIDTH = DEF_QUARTER_WIDTH,
    parameter int unsigned GAP           = DEF_GAP,
    parameter int unsigned DEPTH         = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    coin_pulse_generator_if.slave  req,
    output logic                   coinSensor,
    output logic                   busy,
    output logic [7:0]             sent_count,
    output logic                   illegal
);

    localparam int unsigned MAX_LEN = maxU(maxU(DIME_WIDTH, NICKEL_WIDTH), maxU(QUARTER_WIDTH, GAP));
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    if (DIME_WIDTH < 1 || NICKEL_WIDTH < 1 || QUARTER_WIDTH < 1) begin : gBadWidth
        $error("coin_pulse_generator: pulse widths must be >= 1");
    end
    if (GAP < 1) begin : gBadGap
        $error("coin_pulse_generator: GAP must be >= 1");
    end
    if (DIME_WIDTH == NICKEL_WIDTH || DIME_WIDTH == QUARTER_WIDTH || NICKEL_WIDTH == QUARTER_WIDTH) begin : gSameWidth
        $error("coin_pulse_generator: coin widths must be distinct");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("coin_pulse_generator: DEPTH must be a power of two >= 2");
    end

    gen_state_t         state;
    gen_state_t         stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cntNext;
    logic [CNT_W-1:0]   loadVal;
    logic               sensorNext;
    logic [7:0]         sentNext;
    logic               illegalNext;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifoFull;
    logic               fifoEmpty;
    coin_t              fifoHead;

    // Ready depends only on registered FIFO occupancy
    assign req.coin_ready = !fifoFull;
    assign accept         = req.coin_valid && req.coin_ready;
    assign push           = accept && (req.coin_type != NONE);
    assign busy           = (state != GEN_IDLE) || !fifoEmpty;

    coin_req_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (req.coin_type),
        .pop      (pop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Counter preload for the coin at the FIFO head
    always_comb begin
        loadVal = CNT_W'(DIME_WIDTH - 1);
        case (fifoHead)
            NICKEL:  loadVal = CNT_W'(NICKEL_WIDTH - 1);
            QUARTER: loadVal = CNT_W'(QUARTER_WIDTH - 1);
            default: loadVal = CNT_W'(DIME_WIDTH - 1);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= GEN_IDLE;
            cnt        <= '0;
            coinSensor <= 1'b0;
            sent_count <= 8'd0;
            illegal    <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            coinSensor <= sensorNext;
            sent_count <= sentNext;
            illegal    <= illegalNext;
        end
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        sensorNext  = coinSensor;
        sentNext    = sent_count;
        pop         = 1'b0;
        illegalNext = illegal || (accept && (req.coin_type == NONE));

        case (state)
            GEN_IDLE: begin
                if (!fifoEmpty) begin
                    pop        = 1'b1;
                    stateNext  = GEN_PULSE;
                    sensorNext = 1'b1;
                    cntNext    = loadVal;
                end
            end
            GEN_PULSE: begin
                if (cnt != '0) begin
                    cntNext = cnt - CNT_W'(1);
                end else begin
                    sensorNext = 1'b0;
                    sentNext   = sent_count + 8'd1;
                    stateNext  = GEN_GAP;
                    cntNext    = CNT_W'(GAP - 1);
                end
            end
            GEN_GAP: begin
                // A waiting request starts right after the gap, no idle cycle between
                if (cnt != '0) begin
                    cntNext = cnt - CNT_W'(1);
                end else if (!fifoEmpty) begin
                    pop        = 1'b1;
                    stateNext  = GEN_PULSE;
                    sensorNext = 1'b1;
                    cntNext    = loadVal;
                end else begin
                    stateNext = GEN_IDLE;
                end
            end
            default: begin
                stateNext  = GEN_IDLE;
                sensorNext = 1'b0;
                cntNext    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_coin_pulse_generator.sv
// Directed bench for coin_pulse_generator: per-cycle vector table plus
// hand-written sequences for FIFO overflow, NONE requests and mid-pulse reset.
module tb_coin_pulse_generator;
    import coin_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       coinSensor;
    logic       busy;
    logic [7:0] sent_count;
    logic       illegal;

    always #5 clk = ~clk;

    coin_pulse_generator_if bus();

    coin_pulse_generator dut (
        .clk        (clk),
        .reset      (reset),
        .req        (bus),
        .coinSensor (coinSensor),
        .busy       (busy),
        .sent_count (sent_count),
        .illegal    (illegal)
    );

    typedef struct {
        logic       valid;
        coin_t      ctype;
        logic       sensor;
        logic       ready;
        logic       busy;
        logic [7:0] sent;
        logic       illegal;
    } vec_t;

    vec_t vecs[$];
    int   nChecks = 0;
    int   nFail   = 0;

    function automatic void addRows(int n, logic v, coin_t t, logic s, logic r,
                                    logic b, logic [7:0] c, logic i);
        for (int k = 0; k < n; k++) vecs.push_back('{v, t, s, r, b, c, i});
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1ns after the rising edge
    task automatic tick(logic v, coin_t t);
        @(negedge clk);
        bus.coin_valid = v;
        bus.coin_type  = t;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.coin_type  = NONE;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted, stallAt, run, lowRun, highs, busyCycles;
        int widths[$];
        int gaps[$];
        logic rdy, v, done;

        reset          = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin_type  = NONE;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Idle after reset, single DIME, then DIME/NICKEL/QUARTER back to back
        addRows(5,  1'b0, NONE,    1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        addRows(1,  1'b1, DIME,    1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        addRows(3,  1'b0, NONE,    1'b1, 1'b1, 1'b1, 8'd0, 1'b0);
        addRows(2,  1'b0, NONE,    1'b0, 1'b1, 1'b1, 8'd1, 1'b0);
        addRows(2,  1'b0, NONE,    1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
        addRows(1,  1'b1, DIME,    1'b0, 1'b1, 1'b1, 8'd1, 1'b0);
        addRows(1,  1'b1, NICKEL,  1'b1, 1'b1, 1'b1, 8'd1, 1'b0);
        addRows(1,  1'b1, QUARTER, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);
        addRows(1,  1'b0, NONE,    1'b1, 1'b1, 1'b1, 8'd1, 1'b0);
        addRows(2,  1'b0, NONE,    1'b0, 1'b1, 1'b1, 8'd2, 1'b0);
        addRows(7,  1'b0, NONE,    1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
        addRows(2,  1'b0, NONE,    1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
        addRows(11, 1'b0, NONE,    1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
        addRows(2,  1'b0, NONE,    1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
        addRows(2,  1'b0, NONE,    1'b0, 1'b1, 1'b0, 8'd4, 1'b0);

        foreach (vecs[i]) begin
            tick(vecs[i].valid, vecs[i].ctype);
            check($sformatf("vec%0d.coinSensor", i), 32'(coinSensor), 32'(vecs[i].sensor));
            check($sformatf("vec%0d.coin_ready", i), 32'(bus.coin_ready), 32'(vecs[i].ready));
            check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d.sent_count", i), 32'(sent_count), 32'(vecs[i].sent));
            check($sformatf("vec%0d.illegal", i), 32'(illegal), 32'(vecs[i].illegal));
        end

        // Six QUARTERs with valid held: five accepts before the FIFO fills
        doReset();
        accepted = 0; stallAt = -1; run = 0; lowRun = 0; done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            bus.coin_valid = (accepted < 6);
            bus.coin_type  = QUARTER;
            v   = bus.coin_valid;
            rdy = bus.coin_ready;
            @(posedge clk);
            #1;
            if (v && rdy) accepted++;
            if (v && !rdy && stallAt < 0) stallAt = accepted;
            if (coinSensor) begin
                if (run == 0 && widths.size() > 0) gaps.push_back(lowRun);
                run++;
                lowRun = 0;
            end else begin
                if (run > 0) widths.push_back(run);
                run = 0;
                lowRun++;
            end
            done = (accepted == 6) && !busy;
        end
        check("overflow.done", 32'(done), 32'(1));
        check("overflow.stall_after_accepts", 32'(stallAt), 32'(5));
        check("overflow.accepted", 32'(accepted), 32'(6));
        check("overflow.pulses", 32'(widths.size()), 32'(6));
        foreach (widths[i]) check($sformatf("overflow.width%0d", i), 32'(widths[i]), 32'(11));
        foreach (gaps[i]) check($sformatf("overflow.gap%0d", i), 32'(gaps[i]), 32'(2));
        check("overflow.sent_count", 32'(sent_count), 32'(6));

        // NONE request: handshake completes, flags illegal, nothing queued
        tick(1'b1, NONE);
        check("none.illegal", 32'(illegal), 32'(1));
        check("none.busy", 32'(busy), 32'(0));
        check("none.coinSensor", 32'(coinSensor), 32'(0));
        highs = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, NONE);
            if (coinSensor) highs++;
        end
        check("none.no_pulse", 32'(highs), 32'(0));
        check("none.sent_count", 32'(sent_count), 32'(6));

        tick(1'b1, NICKEL);
        highs = 0;
        for (int k = 0; k < 50; k++) begin
            tick(1'b0, NONE);
            if (coinSensor) highs++;
            if (!busy) break;
        end
        check("nickel.width", 32'(highs), 32'(7));
        check("nickel.sent_count", 32'(sent_count), 32'(7));
        check("nickel.illegal_sticky", 32'(illegal), 32'(1));

        // Reset during cycle 5 of a QUARTER pulse with two more queued
        tick(1'b1, QUARTER);
        tick(1'b1, QUARTER);
        tick(1'b1, QUARTER);
        tick(1'b0, NONE);
        tick(1'b0, NONE);
        tick(1'b0, NONE);
        check("midreset.pre_sensor", 32'(coinSensor), 32'(1));
        #2;
        reset = 1'b0;
        #1;
        check("midreset.coinSensor", 32'(coinSensor), 32'(0));
        check("midreset.busy", 32'(busy), 32'(0));
        check("midreset.coin_ready", 32'(bus.coin_ready), 32'(1));
        check("midreset.sent_count", 32'(sent_count), 32'(0));
        check("midreset.illegal", 32'(illegal), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        highs = 0; busyCycles = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, NONE);
            if (coinSensor) highs++;
            if (busy) busyCycles++;
        end
        check("midreset.no_pulses", 32'(highs), 32'(0));
        check("midreset.idle", 32'(busyCycles), 32'(0));

        tick(1'b1, DIME);
        highs = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1'b0, NONE);
            if (coinSensor) highs++;
            if (!busy) break;
        end
        check("postreset.dime_width", 32'(highs), 32'(3));
        check("postreset.sent_count", 32'(sent_count), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
